// File: rtl/fire_control_if.sv
// Shot/status bus between the keypad/placement stages, fire_control and the display stage.
`timescale 1ns/1ps
interface fire_control_if #(
  parameter int GRID_CELLS = 36,
  parameter int CNT_W      = 6
);
  logic                  fire;
  logic [GRID_CELLS-1:0] pressed_key;
  logic [GRID_CELLS-1:0] ships;
  logic [GRID_CELLS-1:0] hits;
  logic [GRID_CELLS-1:0] misses;
  logic [CNT_W-1:0]      shots_left;
  logic                  hit_pulse;
  logic                  miss_pulse;
  logic                  repeat_pulse;
  logic                  game_over;
  logic                  win;

  modport master (
    output fire, pressed_key, ships,
    input  hits, misses, shots_left, hit_pulse, miss_pulse, repeat_pulse, game_over, win
  );

  modport slave (
    input  fire, pressed_key, ships,
    output hits, misses, shots_left, hit_pulse, miss_pulse, repeat_pulse, game_over, win
  );
endinterface

// File: rtl/fire_control.sv
// Battleship fire control: qualifies one-hot key presses as shots, keeps hit/miss grids
// and the shot budget, and decides win/loss against a ship map snapshotted at game start.
`timescale 1ns/1ps
module fire_control #(
  parameter int GRID_CELLS = 36,
  parameter int MAX_SHOTS  = 20,
  parameter int CNT_W      = 6
) (
  input  logic           clk,
  input  logic           reset,
  fire_control_if.slave  bus
);

  // state | meaning
  // IDLE  | waiting for fire=1 with a non-empty ship map
  // PLAY  | accepting shots; checks win/out-of-shots on registered grids
  // DONE  | game finished, outputs frozen until reset
  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  localparam logic [GRID_CELLS-1:0] ONE = GRID_CELLS'(1);

  state_t                state;
  logic [GRID_CELLS-1:0] snap;
  logic [GRID_CELLS-1:0] prev_key;
  logic [GRID_CELLS-1:0] hits_q;
  logic [GRID_CELLS-1:0] misses_q;
  logic [CNT_W-1:0]      shots_q;
  logic                  hit_q;
  logic                  miss_q;
  logic                  rep_q;
  logic                  over_q;
  logic                  win_q;

  logic [GRID_CELLS-1:0] key;
  logic                  one_hot;
  logic                  key_evt;
  logic                  already;
  logic                  is_ship;
  logic                  all_hit;

  assign key     = bus.pressed_key;
  assign one_hot = (key != '0) && ((key & (key - ONE)) == '0);
  assign key_evt = one_hot && (key != prev_key);
  assign already = |(key & (hits_q | misses_q));
  assign is_ship = |(key & snap);
  assign all_hit = (hits_q & snap) == snap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      snap     <= '0;
      prev_key <= '0;
      hits_q   <= '0;
      misses_q <= '0;
      shots_q  <= CNT_W'(MAX_SHOTS);
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      rep_q    <= 1'b0;
      over_q   <= 1'b0;
      win_q    <= 1'b0;
    end else begin
      prev_key <= key;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      rep_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.fire && (bus.ships != '0)) begin
            snap  <= bus.ships;
            state <= PLAY;
          end
        end
        PLAY: begin
          // End-of-game test runs on the already-updated grids, so it wins over a new shot.
          if (all_hit) begin
            state  <= DONE;
            over_q <= 1'b1;
            win_q  <= 1'b1;
          end else if (shots_q == '0) begin
            state  <= DONE;
            over_q <= 1'b1;
          end else if (bus.fire && key_evt) begin
            if (already) begin
              rep_q <= 1'b1;
            end else begin
              shots_q <= shots_q - CNT_W'(1);
              if (is_ship) begin
                hits_q <= hits_q | key;
                hit_q  <= 1'b1;
              end else begin
                misses_q <= misses_q | key;
                miss_q   <= 1'b1;
              end
            end
          end
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hits         = hits_q;
  assign bus.misses       = misses_q;
  assign bus.shots_left   = shots_q;
  assign bus.hit_pulse    = hit_q;
  assign bus.miss_pulse   = miss_q;
  assign bus.repeat_pulse = rep_q;
  assign bus.game_over    = over_q;
  assign bus.win          = win_q;

endmodule

// File: doc/fire_control.md
Name: fire_control

Overview:
- Sits directly downstream of the ship-placement stage and consumes its 36-bit ship map (6x6 grid, bit i = cell i).
- Takes one-hot key presses from the keypad decoder as shots.
- Records hit and miss grids, counts remaining shots, and decides win or loss.
- Feeds the display stage with the hit/miss grids and game status.

Parameters:
- GRID_CELLS, 36: number of grid cells; width of every grid vector.
- MAX_SHOTS, 20: shots allowed per game; range 1..63.
- CNT_W, 6: width of the shot counter; must satisfy 2^CNT_W > MAX_SHOTS.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately.
- fire  input  1  play enable; high = shots accepted, low = pause.
- pressed_key  input  GRID_CELLS  one-hot key from the keypad decoder; all-zero = no key.
- ships  input  GRID_CELLS  ship map from the placement stage.
- hits  output  GRID_CELLS  cells shot that contain a ship.
- misses  output  GRID_CELLS  cells shot that are empty.
- shots_left  output  CNT_W  remaining shots.
- hit_pulse  output  1  one-cycle pulse on an accepted hit.
- miss_pulse  output  1  one-cycle pulse on an accepted miss.
- repeat_pulse  output  1  one-cycle pulse when an already-shot cell is pressed.
- game_over  output  1  high in DONE.
- win  output  1  high in DONE when all ship cells are hit.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; hits=0; misses=0; shots_left=MAX_SHOTS.
  - All pulses 0; game_over=0; win=0.
  - The ship snapshot and the previous-key register are cleared.
  - Reset mid-game returns to IDLE with all of the above values.
- FSM states: IDLE, PLAY, DONE.
- IDLE -> PLAY on a clock edge where fire=1 and ships!=0.
  - The same edge latches ships into an internal snapshot.
  - Later changes on ships are ignored until reset.
  - If ships=0, the block stays in IDLE.
- Key qualification:
  - prev_key registers pressed_key every cycle.
  - A key event occurs when pressed_key is exactly one-hot and pressed_key != prev_key.
  - A held key therefore fires once.
  - Zero or multi-hot values never generate an event.
- PLAY with fire=1 and a key event on cell k:
  - Already shot ((hits|misses)[k]=1): repeat_pulse=1 next cycle; no counter or grid change.
  - Otherwise, hit (snapshot[k]=1): hits[k] set, hit_pulse=1, shots_left decrements.
  - Otherwise, miss: misses[k] set, miss_pulse=1, shots_left decrements.
  - Grid, counter and pulse all become visible one cycle after the event edge. Latency = 1.
- PLAY with fire=0: key events are ignored and all state is held (pause). prev_key still tracks pressed_key.
- PLAY -> DONE, evaluated on the post-update values:
  - If (hits & snapshot) == snapshot: win=1, game_over=1.
  - Else if shots_left == 0: win=0, game_over=1.
  - If the last shot is also the winning hit, win takes priority.
  - game_over and win assert on the cycle after the final shot's grid update (2 cycles after the event edge).
- DONE: holds all outputs. Key events are ignored and no pulses occur. Exit only via reset.
- Arithmetic: shots_left never decrements below 0. At most one shot is accepted per cycle.
- Pulses are single-cycle and mutually exclusive. hits & misses is always 0.

Test Plan:
- Reset/start: reset=0 then 1; ships=36'h0_0000_0009 (cells 0,3); fire=1 -> IDLE->PLAY next edge; shots_left=20; hits=misses=0.
- Hit/miss: key=bit0 for 10 cycles -> one hit_pulse; hits=36'h1; shots_left=19. Then key=bit35 -> miss_pulse; misses[35]=1; shots_left=18.
- Repeat/illegal: key=bit0 again after release -> repeat_pulse; shots_left unchanged. Key=36'h3 (multi-hot) -> no pulse, no change.
- Win: key=bit3 -> hit_pulse, then game_over=1 and win=1; subsequent key=bit5 -> no change.
- Loss: MAX_SHOTS=3; ships=36'h8; three misses on bits 0,1,2 -> shots_left=0, game_over=1, win=0. Variant with the 3rd shot on bit 3 -> win=1.
- Pause/reset: fire=0 in PLAY with key=bit1 -> nothing recorded. Assert reset=0 mid-game -> outputs return to reset values asynchronously, before the next clock edge.
